// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the single data-memory port: one outstanding transaction,
// request lock until granted, rvalid timeout abort. Define DATA_MEM_ARB_RR_EN for round-robin.
module data_mem_arbiter #(
  parameter int RVALID_TIMEOUT = 15,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  input  logic [31:0]           m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  input  logic [31:0]           m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [31:0]           data_addr_o,
  output logic                  data_we_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  output logic                  err_o
);

  // state   | meaning
  // ST_IDLE | free; arbitrate, present the request, wait for data_gnt_i
  // ST_WAIT | one transaction outstanding for owner_q; wait for rvalid or timeout
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'(RVALID_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       owner_q, lock_q, sel_q, last_q;
  logic [7:0] cnt_q;

  logic sel, req_valid, issue, granted, in_wait, timeout, rsp, contend_pick;

`ifdef DATA_MEM_ARB_RR_EN
  assign contend_pick = ~last_q;
`else
  // Fixed priority: last_q is kept up to date but does not steer selection.
  logic unused_last;
  assign contend_pick = 1'b0;
  assign unused_last  = last_q;
`endif

  always_comb begin
    sel       = 1'b0;
    req_valid = 1'b0;
    if (lock_q) begin
      // A stalled request stays with its requester even if the other one appears.
      sel       = sel_q;
      req_valid = sel_q ? m1_req_i : m0_req_i;
    end else begin
      req_valid = m0_req_i | m1_req_i;
      sel       = (m0_req_i && m1_req_i) ? contend_pick : m1_req_i;
    end
  end

  assign issue   = (state_q == ST_IDLE) && req_valid;
  assign granted = issue && data_gnt_i;
  assign in_wait = (state_q == ST_WAIT);
  assign timeout = in_wait && !data_rvalid_i && (cnt_q == TO_LAST);
  assign rsp     = in_wait && (data_rvalid_i || timeout);

  always_comb begin
    state_d      = state_q;
    data_req_o   = issue;
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_wdata_o = '0;
    m0_gnt_o     = granted && !sel;
    m1_gnt_o     = granted && sel;
    m0_rvalid_o  = rsp && !owner_q;
    m1_rvalid_o  = rsp && owner_q;
    m0_rdata_o   = '0;
    m1_rdata_o   = '0;
    err_o        = timeout;
    if (issue) begin
      data_addr_o  = sel ? m1_addr_i  : m0_addr_i;
      data_we_o    = sel ? m1_we_i    : m0_we_i;
      data_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
    end
    if (in_wait && !timeout) begin
      m0_rdata_o = data_rdata_i;
      m1_rdata_o = data_rdata_i;
    end
    case (state_q)
      ST_IDLE: if (granted) state_d = ST_WAIT;
      ST_WAIT: if (rsp)     state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      lock_q  <= 1'b0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        // Lock clears on grant and when the locked requester withdraws.
        lock_q <= issue && !data_gnt_i;
        if (issue && !data_gnt_i) sel_q <= sel;
        if (granted) begin
          owner_q <= sel;
          last_q  <= sel;
          cnt_q   <= '0;
        end
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a transaction-level reference model
// checked every cycle plus literal expectations for the key scenarios.
module tb_data_mem_arbiter;

  localparam int DW = 32;
  localparam int TO = 4;
`ifdef DATA_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk_i, rst_i;
  logic          m0_req_i, m0_gnt_o, m0_rvalid_o, m0_we_i;
  logic [31:0]   m0_addr_i;
  logic [DW-1:0] m0_wdata_i, m0_rdata_o;
  logic          m1_req_i, m1_gnt_o, m1_rvalid_o, m1_we_i;
  logic [31:0]   m1_addr_i;
  logic [DW-1:0] m1_wdata_i, m1_rdata_o;
  logic          data_req_o, data_gnt_i, data_rvalid_i, data_we_o, err_o;
  logic [31:0]   data_addr_o;
  logic [DW-1:0] data_wdata_o, data_rdata_i;

  data_mem_arbiter #(.RVALID_TIMEOUT(TO), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory/requester behaviour knobs used by tick()
  bit            mem_gnt_en = 0, mem_auto_rsp = 0, force_rv = 0, rep0 = 0, rep1 = 0;
  logic [DW-1:0] rsp_data = '0;
  bit            granted_last = 0, gnt0_last = 0, gnt1_last = 0;

  // Reference model: -1 means none
  int pend = -1, owner = -1, age = 0, last_w = 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] all_outs();
    return {data_req_o, data_addr_o, data_we_o, data_wdata_o, m0_gnt_o, m1_gnt_o,
            m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o, err_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
    data_gnt_i    = mem_gnt_en;
    data_rvalid_i = (mem_auto_rsp && granted_last) || force_rv;
    data_rdata_i  = rsp_data;
    if (gnt0_last && !rep0) m0_req_i = 1'b0;
    if (gnt1_last && !rep1) m1_req_i = 1'b0;
  endtask

  // Per-cycle model compare, then model advance
  always @(negedge clk_i) begin
    logic [5:0]    act_c, exp_c;
    logic [DW-1:0] e_rd;
    logic [64:0]   e_bus;
    int            who;
    bit            active, to_hit;
    act_c = {data_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, err_o};
    if (rst_i) begin
      chk("model_reset_outs", all_outs(), '0);
      pend = -1; owner = -1; age = 0; last_w = 1;
    end else if (owner < 0) begin
      if (pend >= 0) begin
        who = pend; active = (who == 0) ? m0_req_i : m1_req_i;
      end else if (m0_req_i && m1_req_i) begin
        who = RR ? 1 - last_w : 0; active = 1;
      end else begin
        who = m1_req_i ? 1 : 0; active = m0_req_i || m1_req_i;
      end
      exp_c = {active, active && data_gnt_i && who == 0, active && data_gnt_i && who == 1, 3'b000};
      chk("model_ctrl_idle", act_c, exp_c);
      if (active) begin
        e_bus = (who == 0) ? {m0_addr_i, m0_we_i, m0_wdata_i} : {m1_addr_i, m1_we_i, m1_wdata_i};
        chk("model_req_bus", {data_addr_o, data_we_o, data_wdata_o}, e_bus);
      end
      if (active && data_gnt_i) begin
        owner = who; last_w = who; age = 1; pend = -1;
      end else begin
        pend = active ? who : -1;
      end
    end else begin
      to_hit = !data_rvalid_i && (age == TO);
      exp_c = {3'b000, (data_rvalid_i || to_hit) && owner == 0,
               (data_rvalid_i || to_hit) && owner == 1, to_hit};
      chk("model_ctrl_wait", act_c, exp_c);
      e_rd = to_hit ? '0 : data_rdata_i;
      if (exp_c[2]) chk("model_rdata0", m0_rdata_o, e_rd);
      if (exp_c[1]) chk("model_rdata1", m1_rdata_o, e_rd);
      if (data_rvalid_i || to_hit) owner = -1;
      else age++;
    end
    granted_last = data_req_o && data_gnt_i;
    gnt0_last    = m0_gnt_o;
    gnt1_last    = m1_gnt_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int gseq[$];
    rst_i = 1; m0_req_i = 0; m1_req_i = 0; m0_we_i = 0; m1_we_i = 0;
    m0_addr_i = '0; m1_addr_i = '0; m0_wdata_i = '0; m1_wdata_i = '0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0;

    // Reset state
    tick(); tick(); #2;
    chk("reset_outs", all_outs(), '0);
    rst_i = 0;

    // Single read
    mem_gnt_en = 1; mem_auto_rsp = 1; rsp_data = 32'hDEADBEEF;
    tick();
    m0_req_i = 1; m0_addr_i = 32'h100; m0_we_i = 0;
    #2;
    chk("single_gnt", {m0_gnt_o, m1_gnt_o, data_req_o}, 3'b101);
    chk("single_addr", data_addr_o, 32'h100);
    tick(); #2;
    chk("single_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b10);
    chk("single_rdata", m0_rdata_o, 32'hDEADBEEF);
    tick(); #2;
    chk("single_idle", {m0_rvalid_o, m1_rvalid_o, data_req_o}, 3'b000);

    // Contention from fresh reset
    rst_i = 1; tick(); rst_i = 0;
    tick();
    m0_req_i = 1; m1_req_i = 1; rep0 = 1; rep1 = 1;
    m0_addr_i = 32'h10; m1_addr_i = 32'h20; rsp_data = 32'h5;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (m0_gnt_o) gseq.push_back(0);
      if (m1_gnt_o) gseq.push_back(1);
      tick();
    end
    m0_req_i = 0; m1_req_i = 0; rep0 = 0; rep1 = 0;
    chk("cont_count", gseq.size(), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++)
      chk("cont_order", gseq[i], RR ? (i % 2) : 0);
    tick();

    // Lock stability
    mem_gnt_en = 0; rsp_data = 32'hA5A5A5A5;
    tick();
    m1_req_i = 1; m1_addr_i = 32'h200; m1_we_i = 1; m1_wdata_i = 32'h11;
    #2; chk("lock_c0_addr", data_addr_o, 32'h200);
    tick();
    m0_req_i = 1; m0_addr_i = 32'h300; m0_we_i = 0;
    #2; chk("lock_c1_addr", data_addr_o, 32'h200);
    chk("lock_c1_gnt", {m0_gnt_o, m1_gnt_o}, 2'b00);
    tick(); #2; chk("lock_c2_addr", data_addr_o, 32'h200);
    mem_gnt_en = 1;
    tick(); #2;
    chk("lock_c3_gnt", {m0_gnt_o, m1_gnt_o}, 2'b01);
    chk("lock_c3_bus", {data_addr_o, data_we_o, data_wdata_o}, {32'h200, 1'b1, 32'h11});
    tick(); #2; chk("lock_c4_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b01);
    tick(); #2;
    chk("lock_c5_gnt", {m0_gnt_o, m1_gnt_o}, 2'b10);
    chk("lock_c5_addr", data_addr_o, 32'h300);
    tick(); #2; chk("lock_c6_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b10);
    tick();

    // Timeout abort on a write, then a late rvalid
    mem_auto_rsp = 0; rsp_data = 32'hFFFFFFFF;
    tick();
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h400; m0_wdata_i = 32'hCAFE;
    #2; chk("to_gnt", m0_gnt_o, 1'b1);
    for (int k = 1; k < TO; k++) begin
      tick(); #2; chk("to_wait", {m0_rvalid_o, err_o}, 2'b00);
    end
    tick(); #2;
    chk("to_abort", {m0_rvalid_o, m1_rvalid_o, err_o}, 3'b101);
    chk("to_rdata", m0_rdata_o, 32'h0);
    force_rv = 1;
    tick(); #2;
    chk("to_late_ignored", {data_req_o, m0_rvalid_o, m1_rvalid_o, err_o}, 4'b0000);
    force_rv = 0;

    // rvalid exactly in the last WAIT cycle beats the timeout
    tick();
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h500;
    #2; chk("edge_gnt", m0_gnt_o, 1'b1);
    for (int k = 1; k < TO; k++) tick();
    force_rv = 1; rsp_data = 32'h12345678;
    tick(); #2;
    chk("edge_rvalid", {m0_rvalid_o, err_o}, 2'b10);
    chk("edge_rdata", {m0_rdata_o, m1_rdata_o}, {32'h12345678, 32'h12345678});
    force_rv = 0;
    tick();

    // Reset mid-transaction
    tick();
    m1_req_i = 1; m1_addr_i = 32'h600; m1_we_i = 0;
    #2; chk("rst_mid_gnt", m1_gnt_o, 1'b1);
    tick(); #2;
    rst_i = 1; data_rvalid_i = 1;
    #1; chk("rst_mid_outs", all_outs(), '0);
    tick();
    rst_i = 0; mem_auto_rsp = 1;
    tick();
    m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'h700; m1_addr_i = 32'h800;
    #2; chk("rst_first_cont", {m0_gnt_o, m1_gnt_o}, 2'b10);
    tick(); tick(); #2;
    chk("rst_second_cont", {m0_gnt_o, m1_gnt_o}, 2'b01);
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
